// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the pattern sequencer and its run-length detector.
//   ctrl_state_t : controller states IDLE/LOAD/RUN/DRAIN/DONE
//   DET_A..DET_I : bit positions in the detector one-hot state vector
//   DET_RUN_LEN  : run length of equal bits that raises z
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } ctrl_state_t;

  localparam int DET_W = 9;
  localparam int DET_A = 0;
  localparam int DET_B = 1;
  localparam int DET_C = 2;
  localparam int DET_D = 3;
  localparam int DET_E = 4;
  localparam int DET_F = 5;
  localparam int DET_G = 6;
  localparam int DET_H = 7;
  localparam int DET_I = 8;

  localparam logic [DET_W-1:0] DET_ONEHOT_A = 9'b0_0000_0001;

  localparam int DET_RUN_LEN = 4;

endpackage

// File: rtl/seq4_detector.sv
// One-hot detector for DET_RUN_LEN consecutive equal bits.
// B..E track a run of 1..4+ zeros, F..I a run of 1..4+ ones; A is the
// empty-history start state. A change of bit value restarts the run at B
// (zero) or F (one), so z is high exactly when the last four bits agree.
// Ports:
//   Clock, reset_n : clock, synchronous active-low reset (state -> A)
//   clr            : synchronous clear to A
//   en             : consume w this cycle; state holds when low
//   w              : input bit
//   z              : 1 in E or I
//   state          : one-hot {I,H,G,F,E,D,C,B,A}
module seq4_detector
  import seq_ctrl_pkg::*;
(
  input  logic             Clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic             w,
  output logic             z,
  output logic [DET_W-1:0] state
);

  logic [DET_W-1:0] state_q, state_d;

  always_ff @(posedge Clock) begin
    if (!reset_n || clr) state_q <= DET_ONEHOT_A;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = '0;
      if (!w) begin
        state_d[DET_B] = state_q[DET_A] | state_q[DET_F] | state_q[DET_G] |
                         state_q[DET_H] | state_q[DET_I];
        state_d[DET_C] = state_q[DET_B];
        state_d[DET_D] = state_q[DET_C];
        state_d[DET_E] = state_q[DET_D] | state_q[DET_E];
      end else begin
        state_d[DET_F] = state_q[DET_A] | state_q[DET_B] | state_q[DET_C] |
                         state_q[DET_D] | state_q[DET_E];
        state_d[DET_G] = state_q[DET_F];
        state_d[DET_H] = state_q[DET_G];
        state_d[DET_I] = state_q[DET_H] | state_q[DET_I];
      end
    end
  end

  assign z     = state_q[DET_E] | state_q[DET_I];
  assign state = state_q;

endmodule

// File: rtl/seq_detect_sequencer.sv
// Feeds a latched N_BITS pattern MSB-first through seq4_detector and counts
// the cycles on which the detector reports a run of four equal bits.
// Optional feature macro: FIRST_MATCH_EN (records the index of the bit that
// completes the first match; otherwise first_idx/first_vld are tied to 0).
// Ports:
//   Clock, reset_n : clock, synchronous active-low reset
//   start, pattern : start request (accepted in IDLE), pattern sampled then
//   busy, done     : 1 in LOAD/RUN/DRAIN; one-cycle pulse in DONE
//   w_cur, z_cur   : bit presented to / output of the detector this cycle
//   det_state      : detector one-hot state
//   match_count    : saturating count of z=1 cycles in RUN/DRAIN
//   first_idx/vld  : index (0 = MSB) of the bit completing the first match
module seq_detect_sequencer
  import seq_ctrl_pkg::*;
#(
  parameter int N_BITS = 16,
  parameter int CNT_W  = 5
) (
  input  logic              Clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [N_BITS-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              w_cur,
  output logic              z_cur,
  output logic [DET_W-1:0]  det_state,
  output logic [CNT_W-1:0]  match_count,
  output logic [CNT_W-1:0]  first_idx,
  output logic              first_vld
);

  ctrl_state_t       state_q, state_d;
  logic [N_BITS-1:0] shreg;
  logic [CNT_W-1:0]  bit_idx;
  logic              in_load, in_run, in_drain, accept, hit;

  assign in_load  = (state_q == S_LOAD);
  assign in_run   = (state_q == S_RUN);
  assign in_drain = (state_q == S_DRAIN);
  assign accept   = (state_q == S_IDLE) && start;
  // z lags the consumed bit by one cycle, so DRAIN still collects the
  // result of the final bit.
  assign hit      = (in_run || in_drain) && z_cur;

  always_ff @(posedge Clock) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (bit_idx == CNT_W'(N_BITS-1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = in_load || in_run || in_drain;
  assign done  = (state_q == S_DONE);
  assign w_cur = in_run && shreg[N_BITS-1];

  always_ff @(posedge Clock) begin
    if (!reset_n) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      if (accept)      shreg <= pattern;
      else if (in_run) shreg <= {shreg[N_BITS-2:0], 1'b0};
      if (in_load)     bit_idx <= '0;
      else if (in_run) bit_idx <= bit_idx + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!reset_n || in_load)             match_count <= '0;
    else if (hit && (match_count != '1)) match_count <= match_count + 1'b1;
  end

`ifdef FIRST_MATCH_EN
  // bit_idx has already moved past the bit that produced the visible z.
  always_ff @(posedge Clock) begin
    if (!reset_n || in_load) begin
      first_idx <= '0;
      first_vld <= 1'b0;
    end else if (hit && !first_vld) begin
      first_idx <= bit_idx - 1'b1;
      first_vld <= 1'b1;
    end
  end
`else
  assign first_idx = '0;
  assign first_vld = 1'b0;
`endif

  seq4_detector u_det (
    .Clock   (Clock),
    .reset_n (reset_n),
    .clr     (in_load),
    .en      (in_run),
    .w       (w_cur),
    .z       (z_cur),
    .state   (det_state)
  );

endmodule

// File: tb/tb_seq_detect_sequencer.sv
module tb_seq_detect_sequencer;

  localparam int N    = 16;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;
`ifdef FIRST_MATCH_EN
  localparam bit FM = 1'b1;
`else
  localparam bit FM = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          reset_n, start;
  logic [N-1:0]  pattern;
  logic          busy, done, w_cur, z_cur, first_vld;
  logic [8:0]    det_state;
  logic [CW-1:0] match_count, first_idx;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  seq_detect_sequencer #(.N_BITS(N), .CNT_W(CW)) dut (
    .Clock(Clock), .reset_n(reset_n), .start(start), .pattern(pattern),
    .busy(busy), .done(done), .w_cur(w_cur), .z_cur(z_cur),
    .det_state(det_state), .match_count(match_count),
    .first_idx(first_idx), .first_vld(first_vld)
  );

  initial forever #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Detector state from history: length of the trailing run of equal bits
  // among the first k consumed bits (MSB-first), capped at 4.
  function automatic logic [8:0] det_of(input logic [N-1:0] p, input int k);
    int   run;
    logic b;
    if (k == 0) return 9'b1;
    b   = p[N-k];
    run = 1;
    for (int j = k - 2; j >= 0 && run < 4; j--) begin
      if (p[N-1-j] == b) run++;
      else break;
    end
    return 9'b1 << (b ? 4 + run : run);
  endfunction

  // Model: ph = cycles since start accept (0 = idle): 1 LOAD, 2..N+1 RUN
  // (bit ph-2 presented), N+2 DRAIN, N+3 DONE.
  int           ph = 0, dk = 0, cnt = 0, fidx = 0;
  bit           fv = 1'b0;
  logic [N-1:0] mpat = '0, dpat = '0;

  initial forever begin
    logic [8:0] ed;
    logic       ez, ew;
    @(negedge Clock);
    ed = det_of(dpat, dk);
    ez = ed[4] | ed[8];
    ew = (ph >= 2 && ph <= N + 1) ? mpat[N+1-ph] : 1'b0;
    if (chk_en) begin
      check("busy",        busy,        (ph >= 1 && ph <= N + 2));
      check("done",        done,        (ph == N + 3));
      check("w_cur",       w_cur,       ew);
      check("z_cur",       z_cur,       ez);
      check("det_state",   det_state,   ed);
      check("match_count", match_count, cnt);
      check("first_vld",   first_vld,   fv);
      check("first_idx",   first_idx,   fidx);
    end
    // inputs are stable here and are what the next rising edge samples
    if (!reset_n) begin
      ph = 0; cnt = 0; fv = 0; fidx = 0; dk = 0;
    end else begin
      if (ph >= 2 && ph <= N + 2 && ez) begin
        if (cnt < CMAX) cnt++;
        if (FM && !fv) begin fv = 1'b1; fidx = ph - 3; end
      end
      if (ph == 1) begin
        cnt = 0; fv = 0; fidx = 0; dk = 0; dpat = mpat;
      end else if (ph >= 2 && ph <= N + 1) dk++;
      if (ph == 0) begin
        if (start) begin ph = 1; mpat = pattern; end
      end else if (ph == N + 3) ph = 0;
      else ph++;
    end
  end

  task automatic run_pat(input logic [N-1:0] p, input bit pulse_mid, output int n,
                         output bit ei, output logic [N-1:0] zm, output logic [N-1:0] ws);
    start = 1'b1; pattern = p;
    n = 0; ei = 1'b0; zm = '0; ws = '0;
    while (n < 40) begin
      @(posedge Clock); #1; n++;
      if (n == 1) begin start = 1'b0; pattern = N'($urandom); end
      if (pulse_mid && n == 8) start = 1'b1;
      if (pulse_mid && n == 9) start = 1'b0;
      if (n >= 2 && (det_state[4] | det_state[8])) ei = 1'b1;
      if (n >= 3 && n <= 18 && z_cur) zm[n-3] = 1'b1;
      if (n >= 2 && n <= 17) ws[17-n] = w_cur;
      if (done) break;
    end
  endtask

  initial begin
    int           n;
    bit           ei, saw_done;
    logic [N-1:0] zm, ws;
    reset_n = 1'b0; start = 1'b0; pattern = '0;
    @(posedge Clock); #1; chk_en = 1'b1;
    repeat (2) @(posedge Clock); #1;
    check("rst_busy", busy, 0);
    check("rst_det",  det_state, 9'b1);
    check("rst_cnt",  match_count, 0);
    check("rst_w",    w_cur, 0);
    reset_n = 1'b1;
    @(posedge Clock); #1;

    run_pat(16'h0000, 1'b0, n, ei, zm, ws);
    check("lat_0000",  n, 19);
    check("cnt_0000",  match_count, 13);
    check("fidx_0000", first_idx, FM ? 3 : 0);
    check("fvld_0000", first_vld, FM);
    @(posedge Clock); #1;

    run_pat(16'hAAAA, 1'b0, n, ei, zm, ws);
    check("cnt_AAAA",  match_count, 0);
    check("fvld_AAAA", first_vld, 0);
    check("ei_AAAA",   ei, 0);
    @(posedge Clock); #1;

    run_pat(16'hF0F0, 1'b0, n, ei, zm, ws);
    check("cnt_F0F0",  match_count, 4);
    check("fidx_F0F0", first_idx, FM ? 3 : 0);
    check("zmask_F0F0", zm, 16'h8888);
    @(posedge Clock); #1;

    run_pat(16'h0F00, 1'b0, n, ei, zm, ws);
    check("cnt_0F00", match_count, 7);
    check("wseq_0F00", ws, 16'h0F00);
    @(posedge Clock); #1;

    run_pat(16'h0000, 1'b1, n, ei, zm, ws);
    check("lat_pulse", n, 19);
    check("cnt_pulse", match_count, 13);
    @(posedge Clock); #1;
    check("idle_hold_cnt",  match_count, 13);
    check("idle_hold_busy", busy, 0);

    // abort at bit 8 of 16'hFFFF
    start = 1'b1; pattern = 16'hFFFF;
    for (int i = 1; i <= 10; i++) begin
      @(posedge Clock); #1;
      if (i == 1) start = 1'b0;
    end
    reset_n = 1'b0;
    @(posedge Clock); #1;
    check("abort_busy", busy, 0);
    check("abort_det",  det_state, 9'b1);
    check("abort_cnt",  match_count, 0);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (25) begin
      @(posedge Clock); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);

    // random starts (including held starts), patterns and rare resets
    for (int i = 0; i < 1500; i++) begin
      start   = ($urandom_range(2) == 0);
      pattern = N'($urandom);
      reset_n = ($urandom_range(299) != 0);
      @(posedge Clock); #1;
    end
    reset_n = 1'b1; start = 1'b0;
    repeat (25) @(posedge Clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
